// File: rtl/conv_row_core.sv
// Parametrised 1-D convolution row engine: accumulates column beats into N_OUT sums, presents them on valid/ready.
// Optional build macro CONV_ROW_RELU_EN clamps negative presented sums to zero.
module conv_row_core #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int N_ROWS = 16,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int PAD    = 1,
  localparam int N_OUT = (N_ROWS + 2*PAD - K) / STRIDE + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [N_ROWS*DATA_W-1:0]  i_r,
  input  logic [K*DATA_W-1:0]       i_f,
  input  logic                      clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*ACC_W-1:0]    o_sum,
  output logic [15:0]               o_beats
);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  state_t                        state, state_next;
  logic [N_OUT-1:0][ACC_W-1:0]   acc, acc_next, sum_out;
  logic [15:0]                   cnt, cnt_next;
  logic                          accept;

  // One output's contribution for this beat; rows outside 0..N_ROWS-1 are zero padding.
  function automatic logic [ACC_W-1:0] window_sum(
    input int                        j,
    input logic [N_ROWS*DATA_W-1:0]  rows,
    input logic [K*DATA_W-1:0]       taps
  );
    logic [ACC_W-1:0]          s;
    logic signed [DATA_W-1:0]  x;
    logic signed [DATA_W-1:0]  f;
    logic signed [2*DATA_W-1:0] p;
    int                        idx;
    int                        ci;
    s = '0;
    for (int k = 0; k < K; k++) begin
      idx = j*STRIDE + k - PAD;
      ci  = (idx < 0) ? 0 : ((idx >= N_ROWS) ? N_ROWS-1 : idx);
      x   = (idx >= 0 && idx < N_ROWS) ? rows[ci*DATA_W +: DATA_W] : '0;
      f   = taps[k*DATA_W +: DATA_W];
      p   = x * f;
      s   = s + ACC_W'(p);
    end
    return s;
  endfunction

  assign in_ready  = (state == ST_ACC) && !rst;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign cnt_next  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    acc_next = acc;
    sum_out  = '0;
    for (int j = 0; j < N_OUT; j++) begin
      acc_next[j] = acc[j] + window_sum(j, i_r, i_f);
`ifdef CONV_ROW_RELU_EN
      sum_out[j]  = acc_next[j][ACC_W-1] ? '0 : acc_next[j];
`else
      sum_out[j]  = acc_next[j];
`endif
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACC:  if (accept && !clr && in_last) state_next = ST_DONE;
      ST_DONE: if (out_ready)                 state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACC;
    else     state <= state_next;
  end

  // NOTE: the accumulator array is explicitly reset; a window must never start from stale sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      o_sum   <= '0;
      o_beats <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (clr) begin
            acc <= '0;
            cnt <= '0;
          end else if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (in_last) begin
              o_sum   <= sum_out;
              o_beats <= cnt_next;
            end
          end
        end
        ST_DONE: begin
          // clr is ignored here; the presented result is held until handshaken.
          if (out_ready) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_row_core.sv
// Directed self-checking bench for conv_row_core: default geometry plus a stride-1, unpadded 8-row instance.
module tb_conv_row_core;

  localparam int DW  = 8;
  localparam int AW  = 24;
  localparam int NR  = 16;
  localparam int KT  = 3;
  localparam int NO  = 8;
  localparam int NR2 = 8;
  localparam int NO2 = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_last, clr, out_ready;
  logic              in_ready, out_valid;
  logic [NR*DW-1:0]  i_r;
  logic [KT*DW-1:0]  i_f;
  logic [NO*AW-1:0]  o_sum;
  logic [15:0]       o_beats;

  logic              in_valid2, in_last2, out_ready2;
  logic              in_ready2, out_valid2;
  logic [NR2*DW-1:0] i_r2;
  logic [KT*DW-1:0]  i_f2;
  logic [NO2*AW-1:0] o_sum2;
  logic [15:0]       o_beats2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_row_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .i_r(i_r), .i_f(i_f), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .o_sum(o_sum), .o_beats(o_beats)
  );

  conv_row_core #(.N_ROWS(NR2), .K(KT), .STRIDE(1), .PAD(0)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_last(in_last2),
    .i_r(i_r2), .i_f(i_f2), .clr(1'b0), .out_valid(out_valid2), .out_ready(out_ready2),
    .o_sum(o_sum2), .o_beats(o_beats2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_sums(input string tag, input int exp [NO]);
    logic [AW-1:0] e;
    for (int j = 0; j < NO; j++) begin
      e = exp[j];
      check($sformatf("%s.sum%0d", tag, j), {8'b0, o_sum[j*AW +: AW]}, {8'b0, e});
    end
  endtask

  function automatic logic [NR*DW-1:0] fill_rows(input int v);
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [NR*DW-1:0] ramp_rows();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = DW'(i);
    return r;
  endfunction

  task automatic send(input logic [NR*DW-1:0] rows, input logic [KT*DW-1:0] taps, input logic last);
    in_valid = 1'b1;
    i_r      = rows;
    i_f      = taps;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  int exp_ones [NO] = '{2, 3, 3, 3, 3, 3, 3, 3};
  int exp_four [NO] = '{8, 12, 12, 12, 12, 12, 12, 12};
  int exp_ramp [NO] = '{2, 5, 9, 13, 17, 21, 25, 29};
  logic [AW-1:0] held0;
  logic [AW-1:0] e2;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; clr = 1'b0; out_ready = 1'b1;
    i_r = '0; i_f = '0;
    in_valid2 = 1'b0; in_last2 = 1'b0; out_ready2 = 1'b1; i_r2 = '0; i_f2 = '0;
    step(); step();

    // Reset state
    check("rst.in_ready", {31'b0, in_ready}, 32'd0);
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.o_beats", {16'b0, o_beats}, 32'd0);
    check("rst.o_sum", {31'b0, |o_sum}, 32'd0);
    rst = 1'b0;
    step();
    check("idle.in_ready", {31'b0, in_ready}, 32'd1);

    // 1: single beat of ones
    send(fill_rows(1), 24'h010101, 1'b1);
    check("t1.out_valid", {31'b0, out_valid}, 32'd1);
    check("t1.in_ready_busy", {31'b0, in_ready}, 32'd0);
    check_sums("t1", exp_ones);
    check("t1.o_beats", {16'b0, o_beats}, 32'd1);
    step();
    check("t1.out_valid_drop", {31'b0, out_valid}, 32'd0);
    check("t1.in_ready_back", {31'b0, in_ready}, 32'd1);

    // 2: four beats, then a one-beat window to confirm the clear
    send(fill_rows(1), 24'h010101, 1'b0);
    send(fill_rows(1), 24'h010101, 1'b0);
    send(fill_rows(1), 24'h010101, 1'b0);
    check("t2.no_valid_early", {31'b0, out_valid}, 32'd0);
    send(fill_rows(1), 24'h010101, 1'b1);
    check("t2.out_valid", {31'b0, out_valid}, 32'd1);
    check_sums("t2", exp_four);
    check("t2.o_beats", {16'b0, o_beats}, 32'd4);
    step();
    send(fill_rows(1), 24'h010101, 1'b1);
    check_sums("t2b", exp_ones);
    check("t2b.o_beats", {16'b0, o_beats}, 32'd1);
    step();

    // 3: ramp rows, taps (1,-1,2)
    send(ramp_rows(), 24'h02FF01, 1'b1);
    check_sums("t3", exp_ramp);
    step();

    // 4: backpressure; beats and clr offered while DONE are ignored
    out_ready = 1'b0;
    send(fill_rows(1), 24'h010101, 1'b1);
    held0 = o_sum[AW-1:0];
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_last = 1'b1; i_r = fill_rows(5); clr = (c == 2);
      check($sformatf("t4.out_valid%0d", c), {31'b0, out_valid}, 32'd1);
      check($sformatf("t4.in_ready%0d", c), {31'b0, in_ready}, 32'd0);
      step();
      check($sformatf("t4.hold%0d", c), {8'b0, o_sum[AW-1:0]}, {8'b0, held0});
    end
    in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
    check_sums("t4.held", exp_ones);
    out_ready = 1'b1;
    step();
    check("t4.out_valid_drop", {31'b0, out_valid}, 32'd0);
    check("t4.in_ready_back", {31'b0, in_ready}, 32'd1);
    send(fill_rows(1), 24'h010101, 1'b1);
    check("t4.o_beats_after", {16'b0, o_beats}, 32'd1);
    check_sums("t4.after", exp_ones);
    step();

    // 5a: clr aborts a window; the beat presented with clr is dropped but handshaken
    send(fill_rows(1), 24'h010101, 1'b0);
    send(fill_rows(1), 24'h010101, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_last = 1'b1; i_r = fill_rows(4);
    check("t5.in_ready_clr", {31'b0, in_ready}, 32'd1);
    step();
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("t5.no_valid_clr", {31'b0, out_valid}, 32'd0);
    send(fill_rows(1), 24'h010101, 1'b1);
    check_sums("t5a", exp_ones);
    check("t5a.o_beats", {16'b0, o_beats}, 32'd1);
    step();

    // 5b: reset mid-window
    send(fill_rows(1), 24'h010101, 1'b0);
    send(fill_rows(1), 24'h010101, 1'b0);
    rst = 1'b1; clr = 1'b1;
    step();
    check("t5b.in_ready_rst", {31'b0, in_ready}, 32'd0);
    check("t5b.o_sum_rst", {31'b0, |o_sum}, 32'd0);
    check("t5b.o_beats_rst", {16'b0, o_beats}, 32'd0);
    check("t5b.out_valid_rst", {31'b0, out_valid}, 32'd0);
    rst = 1'b0; clr = 1'b0;
    step();
    send(fill_rows(1), 24'h010101, 1'b1);
    check_sums("t5b", exp_ones);
    check("t5b.o_beats", {16'b0, o_beats}, 32'd1);
    step();

    // 6: stride 1, no padding, 8 rows: every output is 3*(-1)*3
    in_valid2 = 1'b1; in_last2 = 1'b1; i_r2 = {NR2{8'hFF}}; i_f2 = 24'h030303;
    step();
    in_valid2 = 1'b0; in_last2 = 1'b0;
    check("t6.out_valid", {31'b0, out_valid2}, 32'd1);
    check("t6.o_beats", {16'b0, o_beats2}, 32'd1);
`ifdef CONV_ROW_RELU_EN
    e2 = '0;
`else
    e2 = 24'hFFFFF7;
`endif
    for (int j = 0; j < NO2; j++)
      check($sformatf("t6.sum%0d", j), {8'b0, o_sum2[j*AW +: AW]}, {8'b0, e2});
    step();
    check("t6.out_valid_drop", {31'b0, out_valid2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
